// File: rtl/focus_sweep_sched_if.sv
// Signal bundle for focus_sweep_sched: sweep control, frame metrics, host table-write
// request and the shared table write port.
interface focus_sweep_sched_if;
    logic        sweep_en;
    logic        loop_en;
    logic [3:0]  filt_first;
    logic [3:0]  filt_last;
    logic        frame_done;
    logic [31:0] hifreq;
    logic        h_req;
    logic [9:0]  h_ta;
    logic [15:0] h_tdi;
    logic        h_gnt;
    logic        twe;
    logic [9:0]  ta;
    logic [15:0] tdi;
    logic        res_valid;
    logic [3:0]  res_filt;
    logic [31:0] res_val;
    logic        sweep_busy;
    logic        sweep_done;
    logic        sweep_err;
    logic [3:0]  best_filt;
    logic [31:0] best_val;

    modport master (
        output sweep_en, loop_en, filt_first, filt_last, frame_done, hifreq,
               h_req, h_ta, h_tdi,
        input  h_gnt, twe, ta, tdi, res_valid, res_filt, res_val,
               sweep_busy, sweep_done, sweep_err, best_filt, best_val
    );

    modport slave (
        input  sweep_en, loop_en, filt_first, filt_last, frame_done, hifreq,
               h_req, h_ta, h_tdi,
        output h_gnt, twe, ta, tdi, res_valid, res_filt, res_val,
               sweep_busy, sweep_done, sweep_err, best_filt, best_val
    );
endinterface

// File: rtl/focus_sweep_sched.sv
// Focus filter sweep scheduler: steps a filter index through a table write port, measures
// one sharpness value per filter, and arbitrates the port with host writes.
// Optional best-result tracker enabled by defining FOCUS_SWEEP_BEST_EN.
module focus_sweep_sched #(
    parameter logic [9:0] TAB_FSEL_ADDR = 10'h3C5
) (
    input logic               sclk,
    input logic               rst,
    focus_sweep_sched_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StSkip, StMeas} state_e;

    state_e      r_state;
    logic [3:0]  r_cur;
    logic [3:0]  r_first;
    logic [3:0]  r_last;
    logic        r_loop;
    logic        r_en_prev;
    logic        r_twe;
    logic        r_gnt;
    logic [9:0]  r_ta;
    logic [15:0] r_tdi;
    logic        r_res_valid;
    logic [3:0]  r_res_filt;
    logic [31:0] r_res_val;
    logic        r_done;
    logic        r_err;
`ifdef FOCUS_SWEEP_BEST_EN
    logic [3:0]  r_best_filt;
    logic [31:0] r_best_val;
`endif

    logic w_en_rise;
    logic w_range_ok;
    logic w_load_wr;
    logic w_host_wr;

    assign w_en_rise  = bus.sweep_en & ~r_en_prev;
    assign w_range_ok = (bus.filt_first <= bus.filt_last) && (bus.filt_last <= 4'd14);
    // Dropping sweep_en cancels a pending sweep write in the same cycle.
    assign w_load_wr  = (r_state == StLoad) && bus.sweep_en;
    assign w_host_wr  = bus.h_req && !w_load_wr;

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cur       <= 4'd0;
            r_first     <= 4'd0;
            r_last      <= 4'd0;
            r_loop      <= 1'b0;
            r_en_prev   <= 1'b0;
            r_twe       <= 1'b0;
            r_gnt       <= 1'b0;
            r_ta        <= 10'd0;
            r_tdi       <= 16'd0;
            r_res_valid <= 1'b0;
            r_res_filt  <= 4'd0;
            r_res_val   <= 32'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef FOCUS_SWEEP_BEST_EN
            r_best_filt <= 4'd0;
            r_best_val  <= 32'd0;
`endif
        end else begin
            r_en_prev   <= bus.sweep_en;
            r_twe       <= 1'b0;
            r_gnt       <= 1'b0;
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;

            if (w_load_wr) begin
                r_twe <= 1'b1;
                r_ta  <= TAB_FSEL_ADDR;
                r_tdi <= {12'h000, r_cur};
            end else if (w_host_wr) begin
                r_twe <= 1'b1;
                r_gnt <= 1'b1;
                r_ta  <= bus.h_ta;
                r_tdi <= bus.h_tdi;
            end

            if (!bus.sweep_en) begin
                r_state <= StIdle;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (w_en_rise) begin
                            if (w_range_ok) begin
                                r_cur   <= bus.filt_first;
                                r_first <= bus.filt_first;
                                r_last  <= bus.filt_last;
                                r_loop  <= bus.loop_en;
                                r_state <= StLoad;
`ifdef FOCUS_SWEEP_BEST_EN
                                r_best_filt <= 4'd0;
                                r_best_val  <= 32'd0;
`endif
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    // The sweep write always wins arbitration, so LOAD lasts one cycle.
                    StLoad: r_state <= StSkip;
                    StSkip: begin
                        if (bus.frame_done) begin
                            r_state <= StMeas;
                        end
                    end
                    StMeas: begin
                        if (bus.frame_done) begin
                            r_res_valid <= 1'b1;
                            r_res_filt  <= r_cur;
                            r_res_val   <= bus.hifreq;
`ifdef FOCUS_SWEEP_BEST_EN
                            if (bus.hifreq > r_best_val) begin
                                r_best_val  <= bus.hifreq;
                                r_best_filt <= r_cur;
                            end
`endif
                            if (r_cur < r_last) begin
                                r_cur   <= r_cur + 4'd1;
                                r_state <= StLoad;
                            end else if (r_loop) begin
                                r_cur   <= r_first;
                                r_state <= StLoad;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= StIdle;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.h_gnt      = r_gnt;
    assign bus.twe        = r_twe;
    assign bus.ta         = r_ta;
    assign bus.tdi        = r_tdi;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_filt   = r_res_filt;
    assign bus.res_val    = r_res_val;
    assign bus.sweep_busy = (r_state != StIdle);
    assign bus.sweep_done = r_done;
    assign bus.sweep_err  = r_err;
`ifdef FOCUS_SWEEP_BEST_EN
    assign bus.best_filt  = r_best_filt;
    assign bus.best_val   = r_best_val;
`else
    assign bus.best_filt  = 4'd0;
    assign bus.best_val   = 32'd0;
`endif

endmodule

// File: tb/tb_focus_sweep_sched.sv
// Directed bench for focus_sweep_sched: a cycle-by-cycle vector table for a full sweep,
// host collision and range errors, then sequences for looping, host-only writes and reset.
module tb_focus_sweep_sched;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 sclk = ~sclk;

    focus_sweep_sched_if bus ();

    focus_sweep_sched #(.TAB_FSEL_ADDR(10'h3C5)) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus)
    );

    typedef struct {
        int unsigned en, lp, ff, fl, fd, hf, hr;
        int unsigned twe, gnt, ta, tdi, rv, rf, rval, busy, done, err;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic cyc();
        @(posedge sclk);
        #1;
    endtask

    task automatic drive(input logic en, input logic lp, input logic [3:0] ff,
                         input logic [3:0] fl, input logic fd, input logic [31:0] hf);
        bus.sweep_en   = en;
        bus.loop_en    = lp;
        bus.filt_first = ff;
        bus.filt_last  = fl;
        bus.frame_done = fd;
        bus.hifreq     = hf;
    endtask

    task automatic chk_res(input string tag, input logic rv, input logic [3:0] rf,
                           input logic [31:0] rval);
        chk({tag, ".rv"}, 32'(bus.res_valid), 32'(rv));
        chk({tag, ".rf"}, 32'(bus.res_filt), 32'(rf));
        chk({tag, ".rval"}, bus.res_val, rval);
    endtask

    task automatic chk_best(input string tag, input logic [3:0] bf, input logic [31:0] bv);
`ifdef FOCUS_SWEEP_BEST_EN
        chk({tag, ".best_filt"}, 32'(bus.best_filt), 32'(bf));
        chk({tag, ".best_val"}, bus.best_val, bv);
`else
        chk({tag, ".best_filt"}, 32'(bus.best_filt), 32'd0);
        chk({tag, ".best_val"}, bus.best_val, 32'd0);
`endif
    endtask

    initial begin
        // en lp ff fl fd hf hr | twe gnt ta tdi rv rf rval busy done err
        vt[0]  = '{1, 0, 2, 4,  0, 0,   0, 0, 0, 'h000, 'h0000, 0, 0, 0,   1, 0, 0};
        vt[1]  = '{1, 0, 2, 4,  0, 0,   1, 1, 0, 'h3C5, 'h0002, 0, 0, 0,   1, 0, 0};
        vt[2]  = '{1, 0, 2, 4,  0, 0,   1, 1, 1, 'h011, 'hBEEF, 0, 0, 0,   1, 0, 0};
        vt[3]  = '{1, 0, 2, 4,  1, 50,  0, 0, 0, 'h011, 'hBEEF, 0, 0, 0,   1, 0, 0};
        vt[4]  = '{1, 0, 2, 4,  0, 0,   0, 0, 0, 'h011, 'hBEEF, 0, 0, 0,   1, 0, 0};
        vt[5]  = '{1, 0, 2, 4,  1, 100, 0, 0, 0, 'h011, 'hBEEF, 1, 2, 100, 1, 0, 0};
        vt[6]  = '{1, 1, 0, 15, 0, 0,   0, 1, 0, 'h3C5, 'h0003, 0, 2, 100, 1, 0, 0};
        vt[7]  = '{1, 1, 0, 15, 1, 7,   0, 0, 0, 'h3C5, 'h0003, 0, 2, 100, 1, 0, 0};
        vt[8]  = '{1, 1, 0, 15, 1, 300, 0, 0, 0, 'h3C5, 'h0003, 1, 3, 300, 1, 0, 0};
        vt[9]  = '{1, 1, 0, 15, 0, 0,   0, 1, 0, 'h3C5, 'h0004, 0, 3, 300, 1, 0, 0};
        vt[10] = '{1, 1, 0, 15, 1, 9,   0, 0, 0, 'h3C5, 'h0004, 0, 3, 300, 1, 0, 0};
        vt[11] = '{1, 1, 0, 15, 1, 200, 0, 0, 0, 'h3C5, 'h0004, 1, 4, 200, 0, 1, 0};
        vt[12] = '{1, 1, 0, 15, 0, 0,   0, 0, 0, 'h3C5, 'h0004, 0, 4, 200, 0, 0, 0};
        vt[13] = '{0, 0, 0, 0,  0, 0,   0, 0, 0, 'h3C5, 'h0004, 0, 4, 200, 0, 0, 0};
        vt[14] = '{1, 0, 5, 3,  0, 0,   0, 0, 0, 'h3C5, 'h0004, 0, 4, 200, 0, 0, 1};
        vt[15] = '{0, 0, 0, 0,  0, 0,   0, 0, 0, 'h3C5, 'h0004, 0, 4, 200, 0, 0, 0};
        vt[16] = '{1, 0, 3, 15, 0, 0,   0, 0, 0, 'h3C5, 'h0004, 0, 4, 200, 0, 0, 1};
        vt[17] = '{0, 0, 0, 0,  0, 0,   0, 0, 0, 'h3C5, 'h0004, 0, 4, 200, 0, 0, 0};

        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 32'd0);
        bus.h_req = 1'b0;
        bus.h_ta  = 10'h011;
        bus.h_tdi = 16'hBEEF;
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst.twe", 32'(bus.twe), 32'd0);
        chk("rst.gnt", 32'(bus.h_gnt), 32'd0);
        chk("rst.ta", 32'(bus.ta), 32'd0);
        chk("rst.tdi", 32'(bus.tdi), 32'd0);
        chk("rst.busy", 32'(bus.sweep_busy), 32'd0);
        chk("rst.done", 32'(bus.sweep_done), 32'd0);
        chk("rst.err", 32'(bus.sweep_err), 32'd0);
        chk_res("rst", 1'b0, 4'd0, 32'd0);
        chk_best("rst", 4'd0, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            string t;
            t = $sformatf("row%0d", i);
            drive(1'(vt[i].en), 1'(vt[i].lp), 4'(vt[i].ff), 4'(vt[i].fl), 1'(vt[i].fd),
                  vt[i].hf);
            bus.h_req = 1'(vt[i].hr);
            cyc();
            chk({t, ".twe"}, 32'(bus.twe), vt[i].twe);
            chk({t, ".gnt"}, 32'(bus.h_gnt), vt[i].gnt);
            chk({t, ".ta"}, 32'(bus.ta), vt[i].ta);
            chk({t, ".tdi"}, 32'(bus.tdi), vt[i].tdi);
            chk({t, ".rv"}, 32'(bus.res_valid), vt[i].rv);
            chk({t, ".rf"}, 32'(bus.res_filt), vt[i].rf);
            chk({t, ".rval"}, bus.res_val, vt[i].rval);
            chk({t, ".busy"}, 32'(bus.sweep_busy), vt[i].busy);
            chk({t, ".done"}, 32'(bus.sweep_done), vt[i].done);
            chk({t, ".err"}, 32'(bus.sweep_err), vt[i].err);
            if (i == 11) chk_best("sweep", 4'd3, 32'd300);
        end

        // Looping sweep on a single filter, then cancel in SKIP.
        drive(1'b1, 1'b1, 4'd7, 4'd7, 1'b0, 32'd0);
        cyc();
        chk("loop.busy0", 32'(bus.sweep_busy), 32'd1);
        chk("loop.twe0", 32'(bus.twe), 32'd0);
        for (int k = 0; k < 2; k++) begin
            string t;
            t = $sformatf("loop%0d", k);
            drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 32'd0);
            cyc();
            chk({t, ".twe"}, 32'(bus.twe), 32'd1);
            chk({t, ".tdi"}, 32'(bus.tdi), 32'h0007);
            drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 32'd5);
            cyc();
            chk_res({t, ".skip"}, 1'b0, 4'd4 + 4'(3 * k), (k == 0) ? 32'd200 : 32'd33);
            drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, (k == 0) ? 32'd33 : 32'd44);
            cyc();
            chk_res({t, ".meas"}, 1'b1, 4'd7, (k == 0) ? 32'd33 : 32'd44);
            chk({t, ".done"}, 32'(bus.sweep_done), 32'd0);
            chk({t, ".busy"}, 32'(bus.sweep_busy), 32'd1);
        end
        drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 32'd0);
        cyc();
        chk("loop.rewrite", 32'(bus.twe), 32'd1);
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 32'd0);
        cyc();
        chk("loop.stop_busy", 32'(bus.sweep_busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            bus.frame_done = ~bus.frame_done;
            cyc();
            chk($sformatf("loop.quiet%0d.twe", k), 32'(bus.twe), 32'd0);
            chk($sformatf("loop.quiet%0d.rv", k), 32'(bus.res_valid), 32'd0);
        end
        chk_best("loop", 4'd7, 32'd44);

        // Host write while idle.
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 32'd0);
        bus.h_req = 1'b1;
        bus.h_ta  = 10'h02A;
        bus.h_tdi = 16'h1234;
        cyc();
        chk("host.gnt", 32'(bus.h_gnt), 32'd1);
        chk("host.twe", 32'(bus.twe), 32'd1);
        chk("host.ta", 32'(bus.ta), 32'h02A);
        chk("host.tdi", 32'(bus.tdi), 32'h1234);
        bus.h_req = 1'b0;
        cyc();
        chk("host.twe_off", 32'(bus.twe), 32'd0);
        chk("host.ta_hold", 32'(bus.ta), 32'h02A);

        // Reset in the grant cycle; edge detector must see sweep_en as a fresh rise after.
        drive(1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 32'd0);
        cyc();
        cyc();
        chk("rg.twe", 32'(bus.twe), 32'd1);
        chk("rg.tdi", 32'(bus.tdi), 32'h0001);
        rst = 1'b1;
        cyc();
        chk("rg.twe_off", 32'(bus.twe), 32'd0);
        chk("rg.ta", 32'(bus.ta), 32'd0);
        chk("rg.tdi0", 32'(bus.tdi), 32'd0);
        chk("rg.busy", 32'(bus.sweep_busy), 32'd0);
        chk("rg.gnt", 32'(bus.h_gnt), 32'd0);
        chk_res("rg", 1'b0, 4'd0, 32'd0);
        chk_best("rg", 4'd0, 32'd0);
        rst = 1'b0;
        cyc();
        chk("rg.restart", 32'(bus.sweep_busy), 32'd1);
        bus.sweep_en = 1'b0;
        cyc();
        chk("rg.idle", 32'(bus.sweep_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
